// File: rtl/vend_pkg.sv
// Shared vending-machine payout definitions: coin_sel encodings, coin values and FSM state codes.
// Pure declarations, no logic; imported by the dispenser and the coin picker.
package vend_pkg;

    localparam logic [1:0] COIN_NONE    = 2'b00;
    localparam logic [1:0] COIN_NICKEL  = 2'b01;
    localparam logic [1:0] COIN_DIME    = 2'b10;
    localparam logic [1:0] COIN_QUARTER = 2'b11;

    localparam int DENOM_NICKEL  = 5;
    localparam int DENOM_DIME    = 10;
    localparam int DENOM_QUARTER = 25;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_SELECT   = 3'd1;
    localparam state_t ST_PULSE    = 3'd2;
    localparam state_t ST_WAIT_ACK = 3'd3;
    localparam state_t ST_FINISH   = 3'd4;

endpackage

// File: rtl/vend_coin_pick.sv
// Greedy coin picker: largest denomination not exceeding remaining, plus an unpayable flag for 1..4 cents.
// Purely combinational, zero latency, no handshake.
module vend_coin_pick
    import vend_pkg::*;
#(
    parameter int AMOUNT_W = 8
) (
    input  logic [AMOUNT_W-1:0] remaining,
    output logic [1:0]          coin_sel,
    output logic [AMOUNT_W-1:0] denom,
    output logic                unpayable
);

    always_comb begin
        coin_sel  = COIN_NONE;
        denom     = '0;
        unpayable = 1'b0;
        if (remaining >= AMOUNT_W'(DENOM_QUARTER)) begin
            coin_sel = COIN_QUARTER;
            denom    = AMOUNT_W'(DENOM_QUARTER);
        end else if (remaining >= AMOUNT_W'(DENOM_DIME)) begin
            coin_sel = COIN_DIME;
            denom    = AMOUNT_W'(DENOM_DIME);
        end else if (remaining >= AMOUNT_W'(DENOM_NICKEL)) begin
            coin_sel = COIN_NICKEL;
            denom    = AMOUNT_W'(DENOM_NICKEL);
        end else if (remaining != '0) begin
            unpayable = 1'b1;
        end
    end

endmodule

// File: rtl/vend_change_dispenser.sv
// Change payout: one hopper eject/ack per coin, largest first; per coin 1 + PULSE_CYCLES + ack-wait cycles.
// No backpressure: start is taken only in IDLE. Define CHANGE_TALLY_EN for lifetime per-coin tally outputs.
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int AMOUNT_W     = 8,
    parameter int PULSE_CYCLES = 4,
    parameter int ACK_TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [AMOUNT_W-1:0] amount,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [AMOUNT_W-1:0] remaining,
    output logic [1:0]          coin_sel,
    output logic                coin_pulse,
    input  logic                coin_ack,
`ifdef CHANGE_TALLY_EN
    output logic [7:0]          coin_count,
    output logic [15:0]         tally_q,
    output logic [15:0]         tally_d,
    output logic [15:0]         tally_n
`else
    output logic [7:0]          coin_count
`endif
);

    localparam int CNT_MAX = (PULSE_CYCLES > ACK_TIMEOUT) ? PULSE_CYCLES : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [AMOUNT_W-1:0]   remaining_q, remaining_d;
    logic [1:0]            coin_sel_q, coin_sel_d;
    logic [7:0]            coin_count_q, coin_count_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [1:0]            pick_sel;
    logic [AMOUNT_W-1:0]   pick_denom;
    logic                  pick_unpayable;
    logic                  ack_take;

    vend_coin_pick #(
        .AMOUNT_W (AMOUNT_W)
    ) u_coin_pick (
        .remaining (remaining_q),
        .coin_sel  (pick_sel),
        .denom     (pick_denom),
        .unpayable (pick_unpayable)
    );

    // remaining is frozen from SELECT through WAIT_ACK, so the picker's denom matches the coin in flight.
    assign ack_take = (state_q == ST_WAIT_ACK) && coin_ack;

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        coin_sel_d   = coin_sel_q;
        coin_count_d = coin_count_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_SELECT;
                    remaining_d  = amount;
                    coin_count_d = 8'd0;
                    err_d        = 1'b0;
                end
            end
            ST_SELECT: begin
                cnt_d = '0;
                if (remaining_q == '0) begin
                    state_d = ST_FINISH;
                end else if (pick_unpayable) begin
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    coin_sel_d = pick_sel;
                    state_d    = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                // An ack on the final timeout cycle wins over the jam.
                if (ack_take) begin
                    remaining_d = remaining_q - pick_denom;
                    if (coin_count_q != 8'hFF) begin
                        coin_count_d = coin_count_q + 8'd1;
                    end
                    coin_sel_d = COIN_NONE;
                    state_d    = ST_SELECT;
                end else if (cnt_q == ACK_LAST) begin
                    err_d      = 1'b1;
                    coin_sel_d = COIN_NONE;
                    state_d    = ST_FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            coin_sel_q   <= COIN_NONE;
            coin_count_q <= 8'd0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            coin_sel_q   <= coin_sel_d;
            coin_count_q <= coin_count_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FINISH);
    assign coin_pulse = (state_q == ST_PULSE);
    assign err        = err_q;
    assign remaining  = remaining_q;
    assign coin_sel   = coin_sel_q;
    assign coin_count = coin_count_q;

`ifdef CHANGE_TALLY_EN
    logic [15:0] tally_qtr_q, tally_qtr_d;
    logic [15:0] tally_dime_q, tally_dime_d;
    logic [15:0] tally_nick_q, tally_nick_d;

    always_comb begin
        tally_qtr_d  = tally_qtr_q;
        tally_dime_d = tally_dime_q;
        tally_nick_d = tally_nick_q;
        if (ack_take) begin
            case (coin_sel_q)
                COIN_QUARTER: if (tally_qtr_q != 16'hFFFF) tally_qtr_d = tally_qtr_q + 16'd1;
                COIN_DIME:    if (tally_dime_q != 16'hFFFF) tally_dime_d = tally_dime_q + 16'd1;
                COIN_NICKEL:  if (tally_nick_q != 16'hFFFF) tally_nick_d = tally_nick_q + 16'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tally_qtr_q  <= 16'd0;
            tally_dime_q <= 16'd0;
            tally_nick_q <= 16'd0;
        end else begin
            tally_qtr_q  <= tally_qtr_d;
            tally_dime_q <= tally_dime_d;
            tally_nick_q <= tally_nick_d;
        end
    end

    assign tally_q = tally_qtr_q;
    assign tally_d = tally_dime_q;
    assign tally_n = tally_nick_q;
`endif

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Bench for vend_change_dispenser: greedy-coin scoreboard fed at start, popped on every coin_pulse rise.
// Hopper acks ACK_GAP cycles after each pulse falls unless a scenario models a jam.
module tb_vend_change_dispenser;

    localparam int AMOUNT_W     = 8;
    localparam int PULSE_CYCLES = 4;
    localparam int ACK_TIMEOUT  = 64;
    localparam int ACK_GAP      = 2;
    localparam int PER_COIN     = 1 + PULSE_CYCLES + ACK_GAP + 1;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [AMOUNT_W-1:0] amount;
    logic                busy, done, err, coin_pulse, coin_ack;
    logic [AMOUNT_W-1:0] remaining;
    logic [1:0]          coin_sel;
    logic [7:0]          coin_count;
`ifdef CHANGE_TALLY_EN
    logic [15:0]         tally_q, tally_d, tally_n;
`endif

    int checks   = 0;
    int failures = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    vend_change_dispenser #(
        .AMOUNT_W     (AMOUNT_W),
        .PULSE_CYCLES (PULSE_CYCLES),
        .ACK_TIMEOUT  (ACK_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .amount     (amount),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .remaining  (remaining),
        .coin_sel   (coin_sel),
        .coin_pulse (coin_pulse),
        .coin_ack   (coin_ack),
`ifdef CHANGE_TALLY_EN
        .coin_count (coin_count),
        .tally_q    (tally_q),
        .tally_d    (tally_d),
        .tally_n    (tally_n)
`else
        .coin_count (coin_count)
`endif
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; amount = '0; coin_ack = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives one payout; t_done counts cycles from the cycle start is high (-1 if done never seen).
    task automatic pay(input logic [AMOUNT_W-1:0] amt, input bit ack_on, input bit hold,
                       input int abort_at, output int t_done, output int n_done,
                       output bit busy1, output bit busy_after);
        logic [AMOUNT_W-1:0] r;
        logic [1:0] cur;
        bit prev_pulse;
        int pw, ack_cnt, n_rise, after;
        r = amt;
        while (r >= 5) begin
            if (r >= 25)      begin exp_q.push_back(2'b11); r = r - 8'd25; end
            else if (r >= 10) begin exp_q.push_back(2'b10); r = r - 8'd10; end
            else              begin exp_q.push_back(2'b01); r = r - 8'd5;  end
        end
        t_done = -1; n_done = 0; busy1 = 1'b0; busy_after = 1'b1;
        prev_pulse = 1'b0; pw = 0; ack_cnt = 0; n_rise = 0; after = -1; cur = 2'b00;
        @(negedge clk);
        start = 1'b1; amount = amt;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            coin_ack = 1'b0;
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) coin_ack = 1'b1;
            end
            if (cyc == 1) busy1 = busy;
            if (coin_pulse && !prev_pulse) begin
                n_rise++;
                if (n_rise == abort_at) begin
                    reset = 1'b1; start = 1'b0; coin_ack = 1'b0;
                    exp_q.delete();
                    return;
                end
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL coin_order: unexpected coin coin_sel=%b amount=%0d", coin_sel, amt);
                end else begin
                    cur = exp_q.pop_front();
                    if (coin_sel !== cur) begin
                        failures++;
                        $display("FAIL coin_order: coin_sel=%b expected=%b amount=%0d", coin_sel, cur, amt);
                    end
                end
                pw = 0;
            end else if (coin_pulse) begin
                checks++;
                if (coin_sel !== cur) begin
                    failures++;
                    $display("FAIL coin_sel_stable: coin_sel=%b expected=%b", coin_sel, cur);
                end
            end
            if (coin_pulse) pw++;
            if (!coin_pulse && prev_pulse) begin
                checks++;
                if (pw != PULSE_CYCLES) begin
                    failures++;
                    $display("FAIL pulse_width: got=%0d expected=%0d", pw, PULSE_CYCLES);
                end
                if (ack_on) ack_cnt = ACK_GAP;
            end
            prev_pulse = coin_pulse;
            if (cyc == after) begin
                busy_after = busy;
                start = 1'b0;
            end
            if (done) begin
                n_done++;
                if (t_done < 0) begin
                    t_done = cyc;
                    after  = cyc + 1;
                end
            end
            if (t_done >= 0 && cyc >= t_done + 3) break;
        end
        start = 1'b0; coin_ack = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL coins_left: %0d expected coins never issued amount=%0d", exp_q.size(), amt);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({busy, done, err, coin_pulse} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: busy/done/err/pulse=%b expected=0000", {busy, done, err, coin_pulse});
        end
        checks++;
        if (coin_sel !== 2'b00 || remaining !== '0 || coin_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_values: sel=%b rem=%0d cnt=%0d expected 0", coin_sel, remaining, coin_count);
        end
`ifdef CHANGE_TALLY_EN
        checks++;
        if (tally_q !== 16'd0 || tally_d !== 16'd0 || tally_n !== 16'd0) begin
            failures++;
            $display("FAIL reset_tally: q=%0d d=%0d n=%0d expected 0", tally_q, tally_d, tally_n);
        end
`endif
    endtask

    task automatic test_payout_40();
        int t, n; bit b1, ba;
        pay(8'd40, 1'b1, 1'b0, 0, t, n, b1, ba);
        checks++;
        if (t != 2 + 3 * PER_COIN || n != 1) begin
            failures++;
            $display("FAIL pay40_done: t_done=%0d n_done=%0d expected %0d/1", t, n, 2 + 3 * PER_COIN);
        end
        checks++;
        if (coin_count !== 8'd3 || remaining !== '0 || err !== 1'b0) begin
            failures++;
            $display("FAIL pay40_final: cnt=%0d rem=%0d err=%b expected 3/0/0", coin_count, remaining, err);
        end
        checks++;
        if (b1 !== 1'b1 || ba !== 1'b0) begin
            failures++;
            $display("FAIL pay40_busy: busy_first=%b busy_after_done=%b expected 1/0", b1, ba);
        end
    endtask

    task automatic test_zero();
        int t, n; bit b1, ba;
        pay(8'd0, 1'b1, 1'b0, 0, t, n, b1, ba);
        checks++;
        if (t != 2 || n != 1 || err !== 1'b0) begin
            failures++;
            $display("FAIL zero_amount: t_done=%0d n_done=%0d err=%b expected 2/1/0", t, n, err);
        end
    endtask

    task automatic test_unpayable();
        int t, n; bit b1, ba;
        pay(8'd17, 1'b1, 1'b0, 0, t, n, b1, ba);
        checks++;
        if (err !== 1'b1 || remaining !== 8'd2 || coin_count !== 8'd2) begin
            failures++;
            $display("FAIL unpayable_17: err=%b rem=%0d cnt=%0d expected 1/2/2", err, remaining, coin_count);
        end
        checks++;
        if (t != 2 + 2 * PER_COIN || n != 1) begin
            failures++;
            $display("FAIL unpayable_done: t_done=%0d n_done=%0d expected %0d/1", t, n, 2 + 2 * PER_COIN);
        end
        pay(8'd0, 1'b1, 1'b0, 0, t, n, b1, ba);
        checks++;
        if (err !== 1'b0 || n != 1) begin
            failures++;
            $display("FAIL err_cleared: err=%b n_done=%0d expected 0/1", err, n);
        end
    endtask

    task automatic test_timeout();
        int t, n; bit b1, ba;
        pay(8'd25, 1'b0, 1'b0, 0, t, n, b1, ba);
        checks++;
        if (err !== 1'b1 || remaining !== 8'd25 || coin_count !== 8'd0) begin
            failures++;
            $display("FAIL jam_final: err=%b rem=%0d cnt=%0d expected 1/25/0", err, remaining, coin_count);
        end
        checks++;
        if (t != 2 + PULSE_CYCLES + ACK_TIMEOUT || n != 1 || coin_sel !== 2'b00) begin
            failures++;
            $display("FAIL jam_done: t_done=%0d n_done=%0d sel=%b expected %0d/1/00",
                     t, n, coin_sel, 2 + PULSE_CYCLES + ACK_TIMEOUT);
        end
    endtask

    task automatic test_reset_abort();
        int t, n; bit b1, ba;
        pay(8'd30, 1'b1, 1'b0, 2, t, n, b1, ba);
        @(negedge clk);
        checks++;
        if ({busy, done, err, coin_pulse} !== 4'b0000 || coin_sel !== 2'b00
            || remaining !== '0 || coin_count !== 8'd0) begin
            failures++;
            $display("FAIL abort_reset: busy/done/err/pulse=%b sel=%b rem=%0d cnt=%0d expected all 0",
                     {busy, done, err, coin_pulse}, coin_sel, remaining, coin_count);
        end
        reset = 1'b0;
        pay(8'd0, 1'b1, 1'b0, 0, t, n, b1, ba);
        checks++;
        if (t != 2 || n != 1 || err !== 1'b0) begin
            failures++;
            $display("FAIL abort_recover: t_done=%0d n_done=%0d err=%b expected 2/1/0", t, n, err);
        end
    endtask

    task automatic test_back_to_back();
        int t, n; bit b1, ba;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            pay(8'd35, 1'b1, 1'b1, 0, t, n, b1, ba);
            checks++;
            if (n != 1 || ba !== 1'b0 || coin_count !== 8'd2 || remaining !== '0) begin
                failures++;
                $display("FAIL held_start: run=%0d n_done=%0d busy_after=%b cnt=%0d rem=%0d expected 1/0/2/0",
                         k, n, ba, coin_count, remaining);
            end
        end
`ifdef CHANGE_TALLY_EN
        checks++;
        if (tally_q !== 16'd2 || tally_d !== 16'd2 || tally_n !== 16'd0) begin
            failures++;
            $display("FAIL tally: q=%0d d=%0d n=%0d expected 2/2/0", tally_q, tally_d, tally_n);
        end
`endif
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; amount = '0; coin_ack = 1'b0;
        test_reset();
        test_payout_40();
        test_zero();
        test_unpayable();
        test_timeout();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vend_change_dispenser.md
Name: vend_change_dispenser

Overview:
- Change-return engine of the vending machine: the payout direction, complementing the coin-accept path.
- Takes a change amount from the main vend controller and drives the coin hopper one coin at a time, largest denomination first.
- Each coin is confirmed by a hopper acknowledge before the next one is issued.
- Sits between the vend FSM (start/amount/done) and the hopper drive pins.

Parameters:
- AMOUNT_W, 8, width of change amount in cents.
- PULSE_CYCLES, 4, cycles coin_pulse is held high per coin (>=1).
- ACK_TIMEOUT, 64, cycles to wait for coin_ack before flagging a jam (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request payout; sampled only in IDLE.
- amount  in  AMOUNT_W  change in cents; latched when start is accepted.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  jam or unpayable remainder; sticky until next accepted start.
- remaining  out  AMOUNT_W  cents still owed.
- coin_sel  out  2  00 none, 01 nickel (5), 10 dime (10), 11 quarter (25).
- coin_pulse  out  1  hopper eject strobe.
- coin_ack  in  1  hopper confirms a coin dropped.
- coin_count  out  8  coins issued this payout; saturates at 255.

Behaviour:
- Interface: single clock `clk`; `reset` is synchronous and active-high.
- Reset: state IDLE; busy, done, err, coin_pulse = 0; coin_sel = 00; remaining = 0; coin_count = 0. Reset mid-payout aborts immediately. No done pulse is produced, and a coin already ejected is not accounted.
- States: IDLE, SELECT, PULSE, WAIT_ACK, FINISH.
- IDLE:
  - start=1 latches amount into remaining, clears coin_count and err, goes to SELECT, busy=1.
  - start is ignored in every other state.
- SELECT (1 cycle):
  - remaining==0 -> FINISH.
  - remaining>=25 -> coin_sel=11; >=10 -> 10; >=5 -> 01; then PULSE.
  - 0<remaining<5 -> err=1, FINISH (no coin issued).
- PULSE: coin_pulse=1 for exactly PULSE_CYCLES cycles, coin_sel held stable, then WAIT_ACK. coin_ack is ignored in PULSE.
- WAIT_ACK:
  - coin_pulse=0, coin_sel held.
  - On coin_ack=1: remaining -= denomination, coin_count += 1 (saturating), coin_sel=00, next SELECT.
  - If ACK_TIMEOUT cycles elapse without ack: err=1, remaining unchanged, coin_sel=00, FINISH.
  - An ack arriving on the timeout cycle counts as an ack.
- FINISH (1 cycle): done=1, busy=0 from the next cycle, return to IDLE. A start in the same cycle done is high is not accepted; start is accepted only from IDLE.
- Latency:
  - amount=0: done high 2 cycles after the start edge.
  - Per coin: 1 (SELECT) + PULSE_CYCLES + ack wait.
- Arithmetic: subtraction never underflows, because selection guarantees denomination <= remaining.
- Width: amounts above 2^AMOUNT_W-1 cannot be represented; this is the caller's responsibility.

Optional Feature:
- Macro: CHANGE_TALLY_EN.
- Defined: adds outputs tally_q, tally_d, tally_n (each 16 bits). These are lifetime per-denomination coin counters, incremented on each accepted coin_ack, saturating at 65535, and cleared only by reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package vend_pkg holds:
  - coin_sel encodings (COIN_NONE/NICKEL/DIME/QUARTER);
  - denomination values 5/10/25;
  - the state enum.
- Sub-module vend_coin_pick: combinational remaining -> coin_sel/denomination/unpayable. Reused by the price-display logic.

Test Plan:
- amount=40, hopper acks 2 cycles after each pulse falls -> coin_sel sequence 11,10,01; coin_count=3; remaining=0; err=0; one done pulse.
- amount=0 -> no coin_pulse, done exactly 2 cycles after start, err=0.
- amount=17 -> coins 10,5, then err=1 with remaining=2 and done pulse; next start clears err.
- amount=25, coin_ack never asserted -> after PULSE_CYCLES+ACK_TIMEOUT cycles: err=1, remaining=25, coin_count=0, done pulse.
- amount=30, reset asserted during second PULSE -> next cycle all outputs at reset values; a start of 0 afterwards completes normally.
- CHANGE_TALLY_EN defined, two payouts of 35 -> tally_q=2, tally_d=2, tally_n=0; start held high during busy has no effect.
